// File: rtl/lut_sched_pkg.sv
// Shared types for the LUT layer scheduler: FSM state encoding and the
// widths of the default layer shape (256 inputs, 64 neurons, fan-in 8).
package lut_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_e;

  localparam int IN_BITS_DFLT   = 256;
  localparam int N_NEURONS_DFLT = 64;
  localparam int FANIN_DFLT     = 8;

  localparam int IDX_W    = $clog2(IN_BITS_DFLT);
  localparam int NID_W    = $clog2(N_NEURONS_DFLT);
  localparam int SLOT_W   = $clog2(FANIN_DFLT);
  localparam int TT_DEPTH = N_NEURONS_DFLT << FANIN_DFLT;

  // One neuron's fan-in list; slot 0 sits in the least significant bits.
  typedef logic [FANIN_DFLT-1:0][IDX_W-1:0] idx_word_t;

endpackage

// File: rtl/lut_tt_ram.sv
// Simple dual-port RAM: one lane-enabled write port and one synchronous read port.
// Contents are never reset.
module lut_tt_ram #(
  parameter  int DW    = 1,
  parameter  int DEPTH = 256,
  parameter  int LANES = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = DW / LANES
) (
  input  logic             clk,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed evaluator for one layer of FANIN-input LUT neurons: one
// neuron per cycle through a read-index / gather+lookup / write-back pipeline.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int IN_BITS   = 256,
  parameter int N_NEURONS = 64,
  parameter int FANIN     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_BITS-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         out_data,
  output logic                         busy,
  input  logic                         cfg_idx_we,
  input  logic                         cfg_tt_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_neuron,
  input  logic [$clog2(FANIN)-1:0]     cfg_slot,
  input  logic [$clog2(IN_BITS)-1:0]   cfg_idx,
  input  logic [FANIN-1:0]             cfg_tt_addr,
  input  logic                         cfg_tt_data,
  output logic                         cfg_err
);

  localparam int IW = $clog2(IN_BITS);
  localparam int NW = $clog2(N_NEURONS);
  localparam int CW = NW + 1;

  localparam logic [CW-1:0] LAST_ISSUE = CW'(N_NEURONS - 1);
  localparam logic [CW-1:0] DRAIN_END  = CW'(N_NEURONS + 1);
  localparam logic [IW:0]   IN_LIM     = (IW + 1)'(IN_BITS);
  localparam logic [NW:0]   N_LIM      = (NW + 1)'(N_NEURONS);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IN_BITS-1:0]   in_q, in_d;
  logic [N_NEURONS-1:0] out_q, out_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [NW-1:0]        n1_q, n1_d, n2_q, n2_d;
  logic                 err_q, err_d;

  logic                 cfg_ok;
  logic [FANIN-1:0]     idx_we;
  logic                 tt_we;
  logic [FANIN*IW-1:0]  idx_rd;
  logic [FANIN-1:0]     tt_sel;
  logic                 tt_rd;

  assign cfg_ok = (state_q == IDLE) && ({1'b0, cfg_neuron} < N_LIM);
  assign err_d  = (cfg_idx_we || cfg_tt_we) && !cfg_ok;
  assign tt_we  = cfg_tt_we && cfg_ok;
  assign idx_we = (cfg_idx_we && cfg_ok) ? (FANIN'(1) << cfg_slot) : '0;

  lut_tt_ram #(
    .DW   (1),
    .DEPTH(N_NEURONS << FANIN),
    .LANES(1)
  ) u_tt (
    .clk  (clk),
    .we   (tt_we),
    .waddr({cfg_neuron, cfg_tt_addr}),
    .wdata(cfg_tt_data),
    .raddr({n1_q, tt_sel}),
    .rdata(tt_rd)
  );

  lut_tt_ram #(
    .DW   (FANIN * IW),
    .DEPTH(N_NEURONS),
    .LANES(FANIN)
  ) u_idx (
    .clk  (clk),
    .we   (idx_we),
    .waddr(cfg_neuron),
    .wdata({FANIN{cfg_idx}}),
    .raddr(cnt_q[NW-1:0]),
    .rdata(idx_rd)
  );

  // Indices past the end of the input vector gather a constant 0.
  always_comb begin
    tt_sel = '0;
    for (int k = 0; k < FANIN; k++) begin
      if ({1'b0, idx_rd[k*IW +: IW]} < IN_LIM) tt_sel[k] = in_q[idx_rd[k*IW +: IW]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    v1_d    = (state_q == RUN);
    n1_d    = cnt_q[NW-1:0];
    v2_d    = v1_q;
    n2_d    = n1_q;
    if (v2_q) out_d[n2_q] = tt_rd;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in_data;
          out_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ISSUE) state_d = DRAIN;
      end
      // Counter keeps running past the last neuron to time the two flush cycles.
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DRAIN_END) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      n1_q    <= '0;
      n2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Scoreboard bench for lut_layer_scheduler: a full-size instance checked against
// a truth-table reference model, plus a small odd-sized instance for range edges.
module tb_lut_layer_scheduler;

  localparam int IN_BITS = 256;
  localparam int N       = 64;
  localparam int FANIN   = 8;
  localparam int TT      = 256;
  localparam int S_IN    = 200;
  localparam int S_N     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [IN_BITS-1:0] in_data;
  logic [N-1:0]       out_data;
  logic               cfg_idx_we, cfg_tt_we, cfg_tt_data, cfg_err;
  logic [5:0]         cfg_neuron;
  logic [2:0]         cfg_slot;
  logic [7:0]         cfg_idx, cfg_tt_addr;

  logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [S_IN-1:0]    s_in_data;
  logic [S_N-1:0]     s_out_data;
  logic               s_cfg_idx_we, s_cfg_tt_we, s_cfg_tt_data, s_cfg_err;
  logic [2:0]         s_cfg_neuron, s_cfg_slot;
  logic [7:0]         s_cfg_idx, s_cfg_tt_addr;

  lut_layer_scheduler #(.IN_BITS(IN_BITS), .N_NEURONS(N), .FANIN(FANIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .cfg_idx_we(cfg_idx_we), .cfg_tt_we(cfg_tt_we), .cfg_neuron(cfg_neuron),
    .cfg_slot(cfg_slot), .cfg_idx(cfg_idx), .cfg_tt_addr(cfg_tt_addr),
    .cfg_tt_data(cfg_tt_data), .cfg_err(cfg_err)
  );

  lut_layer_scheduler #(.IN_BITS(S_IN), .N_NEURONS(S_N), .FANIN(FANIN)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy),
    .cfg_idx_we(s_cfg_idx_we), .cfg_tt_we(s_cfg_tt_we), .cfg_neuron(s_cfg_neuron),
    .cfg_slot(s_cfg_slot), .cfg_idx(s_cfg_idx), .cfg_tt_addr(s_cfg_tt_addr),
    .cfg_tt_data(s_cfg_tt_data), .cfg_err(s_cfg_err)
  );

  int         idx_m [N][FANIN];
  bit         tt_m  [N][TT];
  logic [N-1:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [IN_BITS-1:0] rand_vec();
    logic [IN_BITS-1:0] r;
    for (int i = 0; i < IN_BITS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Truth-table address a neuron sees for a given input vector.
  function automatic int addr_of(int n, logic [IN_BITS-1:0] v);
    int a = 0;
    for (int k = 0; k < FANIN; k++) begin
      if (idx_m[n][k] < IN_BITS && v[idx_m[n][k]]) a += (1 << k);
    end
    return a;
  endfunction

  function automatic logic [N-1:0] model(logic [IN_BITS-1:0] v);
    logic [N-1:0] r;
    for (int n = 0; n < N; n++) r[n] = tt_m[n][addr_of(n, v)];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h with no pending expectation", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("result", out_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_BITS-1:0] v, input bit push);
    int w = 0;
    while (!in_ready && w < 300) begin
      tick();
      w++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    if (push) exp_q.push_back(model(v));
    tick();
    in_valid = 1'b0;
    in_data  = rand_vec();
  endtask

  task automatic wait_out(output int cyc, output bit run_ok);
    cyc    = 1;
    run_ok = 1'b1;
    while (!out_valid && cyc < 300) begin
      if (in_ready || !busy) run_ok = 1'b0;
      tick();
      cyc++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wr_tt(input int n, input int a, input bit d);
    cfg_tt_we   = 1'b1;
    cfg_neuron  = 6'(n);
    cfg_tt_addr = 8'(a);
    cfg_tt_data = d;
    tt_m[n][a]  = d;
    tick();
    cfg_tt_we   = 1'b0;
  endtask

  task automatic wr_idx(input int n, input int s, input int ix);
    cfg_idx_we  = 1'b1;
    cfg_neuron  = 6'(n);
    cfg_slot    = 3'(s);
    cfg_idx     = 8'(ix);
    idx_m[n][s] = ix;
    tick();
    cfg_idx_we  = 1'b0;
  endtask

  task automatic s_run(input logic [S_IN-1:0] v, input string tag);
    int w = 0;
    chk({tag, "_s_in_ready"}, s_in_ready, 1);
    s_in_valid = 1'b1;
    s_in_data  = v;
    tick();
    s_in_valid = 1'b0;
    while (!s_out_valid && w < 100) begin
      tick();
      w++;
    end
    chk({tag, "_s_out_valid"}, s_out_valid, 1);
    chk({tag, "_n3_out_of_range"}, s_out_data[3], 0);
    chk({tag, "_n2_in_range"}, s_out_data[2], v[199]);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IN_BITS-1:0] v;
    logic [S_IN-1:0]    sv;
    int cyc, a, n;
    bit run_ok;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_idx_we = 1'b0; cfg_tt_we = 1'b0; cfg_tt_data = 1'b0;
    cfg_neuron = '0; cfg_slot = '0; cfg_idx = '0; cfg_tt_addr = '0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    s_cfg_idx_we = 1'b0; s_cfg_tt_we = 1'b0; s_cfg_tt_data = 1'b0;
    s_cfg_neuron = '0; s_cfg_slot = '0; s_cfg_idx = '0; s_cfg_tt_addr = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    tick();

    // Random layer; neuron 0 is an 8-input AND over inputs 0..7.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < FANIN; k++) idx_m[i][k] = (i == 0) ? k : $urandom_range(IN_BITS - 1);
      for (int j = 0; j < TT; j++) tt_m[i][j] = (i == 0) ? (j == 255) : bit'($urandom_range(1));
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < TT; j++) begin
        cfg_tt_we   = 1'b1;
        cfg_neuron  = 6'(i);
        cfg_tt_addr = 8'(j);
        cfg_tt_data = tt_m[i][j];
        cfg_idx_we  = (j < FANIN);
        cfg_slot    = 3'(j);
        cfg_idx     = (j < FANIN) ? 8'(idx_m[i][j]) : 8'h0;
        tick();
      end
    end
    cfg_tt_we = 1'b0;
    cfg_idx_we = 1'b0;
    chk("cfg_err_idle_write", cfg_err, 0);

    // Small instance: slot 2 of neuron 3 points past the input vector.
    for (int i = 2; i <= 3; i++) begin
      for (int j = 0; j < TT; j++) begin
        s_cfg_tt_we   = 1'b1;
        s_cfg_neuron  = 3'(i);
        s_cfg_tt_addr = 8'(j);
        s_cfg_tt_data = bit'((j >> 2) & 1);
        s_cfg_idx_we  = (j < FANIN);
        s_cfg_slot    = 3'(j);
        s_cfg_idx     = (j != 2) ? 8'(j) : ((i == 3) ? 8'd250 : 8'd199);
        tick();
      end
    end
    s_cfg_tt_we = 1'b0;
    s_cfg_idx_we = 1'b0;
    sv = '0; sv[199] = 1'b1; sv[7:0] = 8'hA5;
    s_run(sv, "s1");
    sv[199] = 1'b0;
    s_run(sv, "s2");
    s_cfg_tt_we = 1'b1; s_cfg_neuron = 3'd6; s_cfg_tt_addr = 8'd4; s_cfg_tt_data = 1'b1;
    tick();
    s_cfg_tt_we = 1'b0;
    chk("s_err_bad_neuron_tt", s_cfg_err, 1);
    s_cfg_idx_we = 1'b1; s_cfg_neuron = 3'd7; s_cfg_slot = 3'd2; s_cfg_idx = 8'd5;
    tick();
    s_cfg_idx_we = 1'b0;
    chk("s_err_bad_neuron_idx", s_cfg_err, 1);
    tick();
    chk("s_err_clears", s_cfg_err, 0);
    sv = {S_IN/8{8'h5A}}; sv[199] = 1'b1;
    s_run(sv, "s3");

    // Latency, run-phase flags, hold stability, back-to-back accept.
    v = rand_vec();
    v[7:0] = 8'hFF;
    send(v, 1'b1);
    wait_out(cyc, run_ok);
    chk("latency", 64'(cyc), 67);
    chk("run_in_ready_low_busy_high", run_ok, 1);
    chk("n0_and_ff", out_data[0], 1);
    repeat (10) tick();
    chk("hold_data", out_data, model(v));
    chk("hold_out_valid", out_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    take();
    chk("post_take_in_ready", in_ready, 1);
    chk("post_take_out_valid", out_valid, 0);
    v = rand_vec();
    v[7:0] = 8'hFE;
    send(v, 1'b1);
    chk("b2b_busy", busy, 1);
    wait_out(cyc, run_ok);
    chk("n0_and_fe", out_data[0], 0);
    take();

    // Reset partway through a run, then rerun the same vector.
    v = rand_vec();
    send(v, 1'b0);
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    send(v, 1'b1);
    wait_out(cyc, run_ok);
    take();

    // Truth-table write attempted during RUN must be dropped.
    v = rand_vec();
    send(v, 1'b1);
    repeat (5) tick();
    a = addr_of(1, v);
    cfg_tt_we = 1'b1; cfg_neuron = 6'd1; cfg_tt_addr = 8'(a); cfg_tt_data = ~tt_m[1][a];
    tick();
    cfg_tt_we = 1'b0;
    chk("err_write_in_run", cfg_err, 1);
    tick();
    chk("err_pulse_one_cycle", cfg_err, 0);
    wait_out(cyc, run_ok);
    take();
    send(v, 1'b1);
    wait_out(cyc, run_ok);
    take();

    // Config write on the accept edge is seen by the run it starts.
    v = rand_vec();
    a = addr_of(5, v);
    tt_m[5][a] = ~tt_m[5][a];
    cfg_tt_we = 1'b1; cfg_neuron = 6'd5; cfg_tt_addr = 8'(a); cfg_tt_data = tt_m[5][a];
    send(v, 1'b1);
    cfg_tt_we = 1'b0;
    chk("err_accept_edge_write", cfg_err, 0);
    wait_out(cyc, run_ok);
    take();

    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < 3; j++) begin
        n = $urandom_range(N - 1);
        wr_tt(n, $urandom_range(TT - 1), bit'($urandom_range(1)));
      end
      wr_idx($urandom_range(N - 1), $urandom_range(FANIN - 1), $urandom_range(IN_BITS - 1));
      v = rand_vec();
      send(v, 1'b1);
      wait_out(cyc, run_ok);
      chk("latency_rand", 64'(cyc), 67);
      repeat ($urandom_range(4)) tick();
      take();
    end

    repeat (3) tick();
    chk("pending_results", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
